// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the control bundle carried down the pipe-control stages.
package pipe_ctrl_pkg;

    // Major opcode values, instruction bits [6:2].
    localparam logic [4:0] OpLoad   = 5'b00000;
    localparam logic [4:0] OpStore  = 5'b01000;
    localparam logic [4:0] OpBranch = 5'b11000;
    localparam logic [4:0] OpOp     = 5'b01100;
    localparam logic [4:0] OpOpImm  = 5'b00100;
    localparam logic [4:0] OpLui    = 5'b01101;
    localparam logic [4:0] OpAuipc  = 5'b00101;
    localparam logic [4:0] OpJal    = 5'b11011;
    localparam logic [4:0] OpJalr   = 5'b11001;
    localparam logic [4:0] OpSwai   = 5'b01010;

    typedef enum logic [1:0] {
        AluAdd     = 2'b00,
        AluCmp     = 2'b01,
        AluFunct   = 2'b10,
        AluPassImm = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        WbAlu  = 2'b00,
        WbMem  = 2'b01,
        WbPc4  = 2'b10,
        WbSwai = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic    reg_write;
        logic    alu_src;
        logic    pc_src;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jal;
        logic    jalr;
        alu_op_e alu_op;
        wb_sel_e mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CtrlBubble = ctrl_t'(0);

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational main decoder: opcode to control bundle plus source-register usage.
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit ENABLE_SWAI = 1'b1
) (
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       use_rs1_o,
    output logic       use_rs2_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = CtrlBubble;
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        illegal_o = 1'b0;
        // Only 32-bit encodings (low bits 11) are decodable.
        if (opcode_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (opcode_i[6:2])
                OpLoad: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.mem_read   = 1'b1;
                    ctrl_o.mem_to_reg = WbMem;
                    ctrl_o.alu_op     = AluAdd;
                    use_rs1_o         = 1'b1;
                end
                OpStore: begin
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.mem_write = 1'b1;
                    ctrl_o.alu_op    = AluAdd;
                    use_rs1_o        = 1'b1;
                    use_rs2_o        = 1'b1;
                end
                OpBranch: begin
                    ctrl_o.branch = 1'b1;
                    ctrl_o.alu_op = AluCmp;
                    use_rs1_o     = 1'b1;
                    use_rs2_o     = 1'b1;
                end
                OpOp: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_op    = AluFunct;
                    use_rs1_o        = 1'b1;
                    use_rs2_o        = 1'b1;
                end
                OpOpImm: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.alu_op    = AluFunct;
                    use_rs1_o        = 1'b1;
                end
                OpLui: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.alu_op    = AluPassImm;
                end
                OpAuipc: begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_src   = 1'b1;
                    ctrl_o.pc_src    = 1'b1;
                    ctrl_o.alu_op    = AluAdd;
                end
                OpJal: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.jal        = 1'b1;
                    ctrl_o.mem_to_reg = WbPc4;
                end
                OpJalr: begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.jalr       = 1'b1;
                    ctrl_o.alu_src    = 1'b1;
                    ctrl_o.mem_to_reg = WbPc4;
                    use_rs1_o         = 1'b1;
                end
                OpSwai: begin
                    if (ENABLE_SWAI) begin
                        ctrl_o.reg_write  = 1'b1;
                        ctrl_o.alu_src    = 1'b1;
                        ctrl_o.mem_write  = 1'b1;
                        ctrl_o.mem_to_reg = WbSwai;
                        use_rs1_o         = 1'b1;
                        use_rs2_o         = 1'b1;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end
                default: illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decode, ID/EX-EX/MEM-MEM/WB control registers, load-use stall
// and EX-stage forwarding selects.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter bit          ENABLE_SWAI = 1'b1,
    parameter bit          ENABLE_FWD  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       id_instr_i,
    input  logic              id_valid_i,
    input  logic              ex_flush_i,
    output logic              stall_o,
    output logic              illegal_o,
    output logic [1:0]        ex_alu_op_o,
    output logic              ex_alu_src_o,
    output logic              ex_pc_src_o,
    output logic              ex_branch_o,
    output logic              ex_jal_o,
    output logic              ex_jalr_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic              wb_reg_write_o,
    output logic [1:0]        wb_mem_to_reg_o,
    output logic [REG_AW-1:0] wb_rd_o
);

    ctrl_t             id_ctrl;
    logic              id_use_rs1, id_use_rs2, id_illegal;
    logic [REG_AW-1:0] id_rd, id_rs1, id_rs2;
    logic              load_use, bubble;

    ctrl_t             idex_ctrl_q, idex_ctrl_d;
    logic [REG_AW-1:0] idex_rd_q, idex_rd_d, idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d;

    logic              exmem_reg_write_q, exmem_mem_read_q, exmem_mem_write_q;
    wb_sel_e           exmem_mem_to_reg_q;
    logic [REG_AW-1:0] exmem_rd_q;

    logic              memwb_reg_write_q;
    wb_sel_e           memwb_mem_to_reg_q;
    logic [REG_AW-1:0] memwb_rd_q;

    logic              unused_funct;
    assign unused_funct = ^{id_instr_i[31:25], id_instr_i[14:12]};

    pipe_ctrl_decode #(
        .ENABLE_SWAI (ENABLE_SWAI)
    ) u_decode (
        .opcode_i  (id_instr_i[6:0]),
        .ctrl_o    (id_ctrl),
        .use_rs1_o (id_use_rs1),
        .use_rs2_o (id_use_rs2),
        .illegal_o (id_illegal)
    );

    // Unused source fields read as x0 so they can never match a hazard or forward.
    assign id_rd  = REG_AW'(id_instr_i[11:7]);
    assign id_rs1 = id_use_rs1 ? REG_AW'(id_instr_i[19:15]) : '0;
    assign id_rs2 = id_use_rs2 ? REG_AW'(id_instr_i[24:20]) : '0;

    assign load_use = id_valid_i && idex_ctrl_q.mem_read && (idex_rd_q != '0) &&
                      ((idex_rd_q == id_rs1) || (idex_rd_q == id_rs2));
    assign stall_o   = load_use && !ex_flush_i;
    assign bubble    = !id_valid_i || ex_flush_i || load_use;
    assign illegal_o = id_valid_i && id_illegal;

    always_comb begin
        idex_ctrl_d = id_ctrl;
        idex_rd_d   = id_rd;
        idex_rs1_d  = id_rs1;
        idex_rs2_d  = id_rs2;
        if (bubble) begin
            idex_ctrl_d = CtrlBubble;
            idex_rd_d   = '0;
            idex_rs1_d  = '0;
            idex_rs2_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_ctrl_q        <= CtrlBubble;
            idex_rd_q          <= '0;
            idex_rs1_q         <= '0;
            idex_rs2_q         <= '0;
            exmem_reg_write_q  <= 1'b0;
            exmem_mem_read_q   <= 1'b0;
            exmem_mem_write_q  <= 1'b0;
            exmem_mem_to_reg_q <= WbAlu;
            exmem_rd_q         <= '0;
            memwb_reg_write_q  <= 1'b0;
            memwb_mem_to_reg_q <= WbAlu;
            memwb_rd_q         <= '0;
        end else begin
            idex_ctrl_q        <= idex_ctrl_d;
            idex_rd_q          <= idex_rd_d;
            idex_rs1_q         <= idex_rs1_d;
            idex_rs2_q         <= idex_rs2_d;
            exmem_reg_write_q  <= idex_ctrl_q.reg_write;
            exmem_mem_read_q   <= idex_ctrl_q.mem_read;
            exmem_mem_write_q  <= idex_ctrl_q.mem_write;
            exmem_mem_to_reg_q <= idex_ctrl_q.mem_to_reg;
            exmem_rd_q         <= idex_rd_q;
            memwb_reg_write_q  <= exmem_reg_write_q;
            memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
            memwb_rd_q         <= exmem_rd_q;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic em_wr, input logic [REG_AW-1:0] em_rd,
                                           input logic mw_wr, input logic [REG_AW-1:0] mw_rd);
        if (em_wr && (em_rd != '0) && (em_rd == rs)) return 2'b10;
        if (mw_wr && (mw_rd != '0) && (mw_rd == rs)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (ENABLE_FWD) begin
            fwd_a_o = fwd_sel(idex_rs1_q, exmem_reg_write_q, exmem_rd_q,
                              memwb_reg_write_q, memwb_rd_q);
            fwd_b_o = fwd_sel(idex_rs2_q, exmem_reg_write_q, exmem_rd_q,
                              memwb_reg_write_q, memwb_rd_q);
        end
    end

    assign ex_alu_op_o     = idex_ctrl_q.alu_op;
    assign ex_alu_src_o    = idex_ctrl_q.alu_src;
    assign ex_pc_src_o     = idex_ctrl_q.pc_src;
    assign ex_branch_o     = idex_ctrl_q.branch;
    assign ex_jal_o        = idex_ctrl_q.jal;
    assign ex_jalr_o       = idex_ctrl_q.jalr;
    assign mem_write_o     = exmem_mem_write_q;
    assign mem_read_o      = exmem_mem_read_q;
    assign wb_reg_write_o  = memwb_reg_write_q;
    assign wb_mem_to_reg_o = memwb_mem_to_reg_q;
    assign wb_rd_o         = memwb_rd_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: a default instance plus one with SWAI and forwarding off.
module tb_pipe_ctrl_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] id_instr_i;
    logic        id_valid_i;
    logic        ex_flush_i;

    logic       stall_o, illegal_o, ex_alu_src_o, ex_pc_src_o, ex_branch_o, ex_jal_o, ex_jalr_o;
    logic       mem_write_o, mem_read_o, wb_reg_write_o;
    logic [1:0] ex_alu_op_o, fwd_a_o, fwd_b_o, wb_mem_to_reg_o;
    logic [4:0] wb_rd_o;

    logic       d2_stall, d2_illegal, d2_alu_src, d2_pc_src, d2_branch, d2_jal, d2_jalr;
    logic       d2_mem_write, d2_mem_read, d2_reg_write;
    logic [1:0] d2_alu_op, d2_fwd_a, d2_fwd_b, d2_mem_to_reg;
    logic [4:0] d2_rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    pipe_ctrl_unit dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .id_instr_i      (id_instr_i),
        .id_valid_i      (id_valid_i),
        .ex_flush_i      (ex_flush_i),
        .stall_o         (stall_o),
        .illegal_o       (illegal_o),
        .ex_alu_op_o     (ex_alu_op_o),
        .ex_alu_src_o    (ex_alu_src_o),
        .ex_pc_src_o     (ex_pc_src_o),
        .ex_branch_o     (ex_branch_o),
        .ex_jal_o        (ex_jal_o),
        .ex_jalr_o       (ex_jalr_o),
        .fwd_a_o         (fwd_a_o),
        .fwd_b_o         (fwd_b_o),
        .mem_write_o     (mem_write_o),
        .mem_read_o      (mem_read_o),
        .wb_reg_write_o  (wb_reg_write_o),
        .wb_mem_to_reg_o (wb_mem_to_reg_o),
        .wb_rd_o         (wb_rd_o)
    );

    pipe_ctrl_unit #(
        .REG_AW      (5),
        .ENABLE_SWAI (1'b0),
        .ENABLE_FWD  (1'b0)
    ) dut2 (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .id_instr_i      (id_instr_i),
        .id_valid_i      (id_valid_i),
        .ex_flush_i      (ex_flush_i),
        .stall_o         (d2_stall),
        .illegal_o       (d2_illegal),
        .ex_alu_op_o     (d2_alu_op),
        .ex_alu_src_o    (d2_alu_src),
        .ex_pc_src_o     (d2_pc_src),
        .ex_branch_o     (d2_branch),
        .ex_jal_o        (d2_jal),
        .ex_jalr_o       (d2_jalr),
        .fwd_a_o         (d2_fwd_a),
        .fwd_b_o         (d2_fwd_b),
        .mem_write_o     (d2_mem_write),
        .mem_read_o      (d2_mem_read),
        .wb_reg_write_o  (d2_reg_write),
        .wb_mem_to_reg_o (d2_mem_to_reg),
        .wb_rd_o         (d2_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [6:0] f7);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] swai(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b0101011};
    endfunction

    function automatic logic [31:0] utype(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
    endfunction

    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    initial begin
        rst_i      = 1'b0;
        id_valid_i = 1'b1;
        ex_flush_i = 1'b0;
        id_instr_i = lw(5'd5, 5'd1);
        #2;
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_mem_read", 32'(mem_read_o), 0);
        chk("rst_wb_reg_write", 32'(wb_reg_write_o), 0);
        chk("rst_alu_src", 32'(ex_alu_src_o), 0);
        chk("rst_fwd_a", 32'(fwd_a_o), 0);
        cyc();
        rst_i = 1'b1;

        // lw x5 then add x6,x5,x2: one stall, bubble, MEM/WB forward
        #1 chk("lw_nostall", 32'(stall_o), 0);
        cyc();
        chk("first_capture_alu_src", 32'(ex_alu_src_o), 1);
        id_instr_i = rtype(5'd6, 5'd5, 5'd2, 7'd0);
        #1 chk("loaduse_stall", 32'(stall_o), 1);
        cyc();
        chk("stall_mem_read", 32'(mem_read_o), 1);
        chk("stall_bubble_alu_op", 32'(ex_alu_op_o), 0);
        chk("stall_bubble_alu_src", 32'(ex_alu_src_o), 0);
        chk("stall_cleared", 32'(stall_o), 0);
        cyc();
        chk("lu_fwd_a", 32'(fwd_a_o), 1);
        chk("lu_fwd_b", 32'(fwd_b_o), 0);
        chk("lu_alu_op", 32'(ex_alu_op_o), 2);
        chk("lu_wb_sel", 32'(wb_mem_to_reg_o), 1);
        chk("lu_wb_rd", 32'(wb_rd_o), 5);
        chk("lu_wb_we", 32'(wb_reg_write_o), 1);
        chk("nofwd_a", 32'(d2_fwd_a), 0);

        // add x3,x1,x2 then sub x4,x3,x3: EX/MEM forward on both operands
        id_instr_i = rtype(5'd3, 5'd1, 5'd2, 7'd0);
        #1 chk("add_nostall", 32'(stall_o), 0);
        cyc();
        chk("add_fwd_a_none", 32'(fwd_a_o), 0);
        id_instr_i = rtype(5'd4, 5'd3, 5'd3, 7'h20);
        #1 chk("sub_nostall", 32'(stall_o), 0);
        cyc();
        chk("sub_fwd_a", 32'(fwd_a_o), 2);
        chk("sub_fwd_b", 32'(fwd_b_o), 2);
        chk("sub_wb_rd", 32'(wb_rd_o), 6);

        // both stages write x7: EX/MEM must win
        id_instr_i = rtype(5'd7, 5'd1, 5'd2, 7'd0);
        cyc();
        id_instr_i = rtype(5'd7, 5'd7, 5'd0, 7'd0);
        cyc();
        chk("x7_fwd_a", 32'(fwd_a_o), 2);
        chk("x0_fwd_b", 32'(fwd_b_o), 0);
        id_instr_i = rtype(5'd8, 5'd7, 5'd7, 7'd0);
        cyc();
        chk("prio_fwd_a", 32'(fwd_a_o), 2);
        chk("prio_fwd_b", 32'(fwd_b_o), 2);
        chk("nofwd_b", 32'(d2_fwd_b), 0);
        id_instr_i = rtype(5'd9, 5'd1, 5'd7, 7'd0);
        cyc();
        chk("memwb_fwd_a", 32'(fwd_a_o), 0);
        chk("memwb_fwd_b", 32'(fwd_b_o), 1);

        // load to x0 never stalls or forwards
        id_instr_i = lw(5'd0, 5'd1);
        cyc();
        id_instr_i = rtype(5'd9, 5'd0, 5'd0, 7'd0);
        #1 chk("x0_nostall", 32'(stall_o), 0);
        cyc();
        chk("x0_nofwd", 32'(fwd_a_o), 0);

        // rs2-only hazard, then flush overrides the stall
        id_instr_i = lw(5'd10, 5'd1);
        cyc();
        id_instr_i = rtype(5'd11, 5'd1, 5'd10, 7'd0);
        #1 chk("rs2_stall", 32'(stall_o), 1);
        ex_flush_i = 1'b1;
        #1 chk("flush_nostall", 32'(stall_o), 0);
        cyc();
        ex_flush_i = 1'b0;
        chk("flush_ex_adv", 32'(mem_read_o), 1);
        chk("flush_bubble", 32'(ex_alu_op_o), 0);
        #1 chk("post_flush_nostall", 32'(stall_o), 0);
        cyc();
        chk("post_flush_fwd_b", 32'(fwd_b_o), 1);

        // LUI's rs1 field aliases the load's rd but is unused
        id_instr_i = lw(5'd12, 5'd1);
        cyc();
        id_instr_i = utype(20'h00060, 5'd13, 7'b0110111);
        #1 chk("lui_nostall", 32'(stall_o), 0);
        cyc();
        chk("lui_alu_op", 32'(ex_alu_op_o), 3);
        chk("lui_alu_src", 32'(ex_alu_src_o), 1);

        // invalid ID and illegal opcode
        id_valid_i = 1'b0;
        id_instr_i = rtype(5'd6, 5'd5, 5'd2, 7'd0);
        cyc();
        chk("invalid_bubble", 32'(ex_alu_op_o), 0);
        id_instr_i = 32'hFFFF_FFFF;
        #1 chk("illegal_gated", 32'(illegal_o), 0);
        id_valid_i = 1'b1;
        #1 chk("illegal", 32'(illegal_o), 1);
        cyc();
        chk("illegal_alu_src", 32'(ex_alu_src_o), 0);
        chk("illegal_alu_op", 32'(ex_alu_op_o), 0);

        // remaining decode classes
        id_instr_i = utype(20'd0, 5'd1, 7'b1101111);
        cyc();
        chk("jal", 32'(ex_jal_o), 1);
        id_instr_i = beq(5'd1, 5'd2);
        cyc();
        chk("beq_branch", 32'(ex_branch_o), 1);
        chk("beq_alu_op", 32'(ex_alu_op_o), 1);
        id_instr_i = utype(20'd0, 5'd2, 7'b0010111);
        cyc();
        chk("auipc_pc_src", 32'(ex_pc_src_o), 1);
        chk("jal_wb_sel", 32'(wb_mem_to_reg_o), 2);
        chk("jal_wb_rd", 32'(wb_rd_o), 1);
        id_instr_i = jalr(5'd1, 5'd5);
        cyc();
        chk("jalr", 32'(ex_jalr_o), 1);
        chk("jalr_alu_src", 32'(ex_alu_src_o), 1);

        // SWAI with and without decode enable
        id_instr_i = swai(5'd16, 5'd1);
        #1 chk("swai_legal", 32'(illegal_o), 0);
        chk("swai_disabled_illegal", 32'(d2_illegal), 1);
        cyc();
        id_valid_i = 1'b0;
        chk("swai_alu_src", 32'(ex_alu_src_o), 1);
        chk("swai_dis_alu_src", 32'(d2_alu_src), 0);
        cyc();
        chk("swai_mem_write", 32'(mem_write_o), 1);
        chk("swai_dis_mem_write", 32'(d2_mem_write), 0);
        cyc();
        chk("swai_wb_sel", 32'(wb_mem_to_reg_o), 3);
        chk("swai_wb_rd", 32'(wb_rd_o), 16);
        chk("swai_dis_wb_we", 32'(d2_reg_write), 0);

        // reset during a stall
        id_valid_i = 1'b1;
        id_instr_i = lw(5'd5, 5'd1);
        cyc();
        id_instr_i = rtype(5'd6, 5'd5, 5'd2, 7'd0);
        #1 chk("pre_rst_stall", 32'(stall_o), 1);
        rst_i = 1'b0;
        #1 chk("mid_rst_stall", 32'(stall_o), 0);
        chk("mid_rst_alu_src", 32'(ex_alu_src_o), 0);
        rst_i = 1'b1;
        #1 chk("post_rst_stall", 32'(stall_o), 0);
        cyc();
        id_valid_i = 1'b0;
        chk("post_rst_e1", 32'(wb_reg_write_o), 0);
        cyc();
        chk("post_rst_e2", 32'(wb_reg_write_o), 0);
        cyc();
        chk("post_rst_e3_we", 32'(wb_reg_write_o), 1);
        chk("post_rst_e3_rd", 32'(wb_rd_o), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- REG_AW, 5, register index width.
- ENABLE_SWAI, 1, SWAI opcode 0101011 decode enable.
- ENABLE_FWD, 1, forwarding enable; 0 forces fwd_a_o/fwd_b_o to 00.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, single clock.
- rst_i, in, 1, asynchronous active-low reset.
- id_instr_i, in, 32, instruction in ID.
- id_valid_i, in, 1, ID holds a real instruction.
- ex_flush_i, in, 1, branch/jump taken resolved in EX.
- stall_o, out, 1, hold PC and IF/ID.
- illegal_o, out, 1, ID opcode undecodable.
- ex_alu_op_o, out, 2, EX ALU opcode.
- ex_alu_src_o, out, 1, EX ALU source-2 select.
- ex_pc_src_o, out, 1, EX ALU source-1 select.
- ex_branch_o, out, 1, EX branch.
- ex_jal_o, out, 1, EX JAL.
- ex_jalr_o, out, 1, EX JALR.
- fwd_a_o, out, 2, forward select for rs1.
- fwd_b_o, out, 2, forward select for rs2.
- mem_write_o, out, 1, MEM-stage write.
- mem_read_o, out, 1, MEM-stage read.
- wb_reg_write_o, out, 1, WB register write.
- wb_mem_to_reg_o, out, 2, WB data select.
- wb_rd_o, out, REG_AW, WB destination register.

Function
REQ-003 Decode SHALL use opcode bits [6:2]:
- LOAD: RegWrite=1, ALUSrc=1, MemRead=1, MemtoReg=01, ALUop=00.
- STORE: ALUSrc=1, MemWrite=1, ALUop=00.
- BRANCH: Branch=1, ALUop=01.
- OP: RegWrite=1, ALUop=10.
- OP_IMM: RegWrite=1, ALUSrc=1, ALUop=10.
- LUI: RegWrite=1, ALUSrc=1, ALUop=11.
- AUIPC: RegWrite=1, ALUSrc=1, PcSrc=1, ALUop=00.
- JAL: RegWrite=1, Jal=1, MemtoReg=10.
- JALR: RegWrite=1, Jalr=1, ALUSrc=1, MemtoReg=10.
- SWAI: RegWrite=1, ALUSrc=1, MemWrite=1, MemtoReg=11.
- All unlisted fields SHALL be 0.

REQ-004 Any other opcode, or SWAI with ENABLE_SWAI=0, SHALL decode to an all-zero bundle with illegal_o=1 while id_valid_i=1.

REQ-005 Control SHALL advance through three registered stages: ID/EX, EX/MEM and MEM/WB. Each stage captures its bundle subset plus rd, and ID/EX also captures rs1 and rs2. Every stage register SHALL update every cycle.

REQ-006 rs1 SHALL be captured only for LOAD, STORE, BRANCH, OP, OP_IMM, JALR and SWAI. rs2 SHALL be captured only for STORE, BRANCH, OP and SWAI. An unused rs field SHALL be stored as 0.

REQ-007 Load-use hazard: stall_o SHALL be 1 combinationally when all of the following hold:
- id_valid_i=1;
- the ID/EX stage has MemRead=1;
- ID/EX rd≠0;
- ID/EX rd equals a used ID rs field.

REQ-008 On a stall cycle, ID/EX SHALL load an all-zero bubble, while EX/MEM and MEM/WB advance normally. The hazard SHALL clear after exactly one stall cycle.

REQ-009 While ex_flush_i=1, ID/EX SHALL load a bubble and stall_o SHALL be forced to 0. Flush SHALL take priority over stall. The EX instruction itself SHALL advance normally.

REQ-010 id_valid_i=0 SHALL load a bubble into ID/EX.

REQ-011 Forwarding (fwd_a_o shown; fwd_b_o is identical using ID/EX rs2):
- 10 if EX/MEM RegWrite=1, EX/MEM rd≠0 and EX/MEM rd equals ID/EX rs1;
- otherwise 01 if MEM/WB RegWrite=1, MEM/WB rd≠0 and MEM/WB rd equals ID/EX rs1;
- otherwise 00.
When both stages match, EX/MEM SHALL win. Outputs SHALL be combinational from stage registers only.

REQ-012 Register x0 SHALL never cause a stall or a forward.

Reset
REQ-013 When rst_i=0, all stage registers SHALL clear asynchronously to bubbles. Consequently stall_o=0, fwd_a_o=fwd_b_o=00, and every EX/MEM/WB output equals 0.

REQ-014 Reset deassertion SHALL be synchronised externally. The first edge after release SHALL load a normal ID/EX capture.

REQ-015 Reset mid-stall SHALL discard the hazard; no stall SHALL persist after release.

Structure
REQ-016 Package pipe_ctrl_pkg SHALL hold:
- opcode constants;
- ALUop encodings (00 add, 01 compare, 10 funct, 11 pass-imm);
- MemtoReg encodings (00 ALU, 01 mem, 10 PC+4, 11 SWAI address);
- the control-bundle struct.

REQ-017 The combinational decoder SHALL be the single sub-module pipe_ctrl_decode. The stage registers, hazard logic and forwarding logic SHALL reside in pipe_ctrl_unit.

Verification
REQ-018 lw x5,0(x1) followed by add x6,x5,x2 -> stall_o=1 for one cycle, then a bubble in EX, then fwd_a_o=01 when the add reaches EX.

REQ-019 add x3,x1,x2 followed by sub x4,x3,x3 -> fwd_a_o=fwd_b_o=10 in the sub's EX cycle, with no stall.

REQ-020 ex_flush_i=1 coincident with a load-use hazard -> stall_o=0, ID/EX becomes a bubble, and the branch proceeds to MEM.

REQ-021 Opcode 0101011 with ENABLE_SWAI=0 -> illegal_o=1 and a zero bundle. With ENABLE_SWAI=1 -> mem_write_o=1 in MEM and wb_mem_to_reg_o=11 in WB.

REQ-022 rst_i pulsed low during a stall -> all outputs 0 immediately, and the first valid instruction after release reaches WB three edges later.
